floor_request_scheduler: RTL and testbench

- Latches cabin and hall call buttons and decides where the elevator goes next, using SCAN (collective) ordering.
- Sits between the button inputs and the elevator motion/door core.
- Drives the direction command, the target floor, a door-open request, and the call lamps.
- Receives floor position and door-cycle completion back from the core.

---
 rtl/floor_request_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_floor_request_scheduler.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/floor_request_scheduler.sv
// SCAN/collective elevator call scheduler: latches cabin and hall calls,
// picks direction and target floor, and requests door cycles.
module floor_request_scheduler #(
  parameter int BUTTONS_WIDTH = 8,
  parameter int FLOOR_BITS    = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [BUTTONS_WIDTH-1:0] btn_in,
  input  logic [BUTTONS_WIDTH-1:0] btn_up_out,
  input  logic [BUTTONS_WIDTH-1:0] btn_down_out,
  input  logic [FLOOR_BITS-1:0]    cur_floor,
  input  logic                     at_floor,
  input  logic                     door_done,
  output logic [1:0]               dir,
  output logic [FLOOR_BITS-1:0]    target,
  output logic                     target_valid,
  output logic                     open_req,
  output logic [BUTTONS_WIDTH-1:0] lamp_in,
  output logic [BUTTONS_WIDTH-1:0] lamp_up,
  output logic [BUTTONS_WIDTH-1:0] lamp_down
);

  localparam int BW = BUTTONS_WIDTH;
  localparam int FB = FLOOR_BITS;

  localparam logic [BW-1:0] UP_MASK = {1'b0, {(BW-1){1'b1}}};
  localparam logic [BW-1:0] DN_MASK = {{(BW-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {S_IDLE, S_UP, S_DOWN, S_STOP} state_t;
  typedef enum logic [1:0] {D_IDLE, D_UP, D_DOWN} svc_t;

  state_t state, state_n;
  svc_t   svc, svc_n;
  logic   turn, turn_n;

  logic          at_in, at_up, at_dn, any_at;
  logic          above, below;
  logic [BW-1:0] cur_oh;
  logic [BW-1:0] clr_in, clr_up, clr_dn;
  logic [FB-1:0] up_near, up_far, dn_near, dn_far;
  logic          up_near_ok, dn_near_ok;
  logic [FB-1:0] up_tgt, dn_tgt, tgt_n;
  logic [1:0]    dir_n;
  int            cf;

  always_comb begin
    cf         = int'(cur_floor);
    at_in      = 1'b0;
    at_up      = 1'b0;
    at_dn      = 1'b0;
    above      = 1'b0;
    below      = 1'b0;
    cur_oh     = '0;
    up_near    = '0;
    up_near_ok = 1'b0;
    dn_near    = '0;
    dn_near_ok = 1'b0;
    up_far     = cur_floor;
    dn_far     = cur_floor;
    for (int i = 0; i < BW; i++) begin
      if (i == cf) begin
        cur_oh[i] = 1'b1;
        at_in     = lamp_in[i];
        at_up     = lamp_up[i];
        at_dn     = lamp_down[i];
      end
      if (i > cf)
        above = above | lamp_in[i] | lamp_up[i] | lamp_down[i];
      if (i < cf)
        below = below | lamp_in[i] | lamp_up[i] | lamp_down[i];
    end
    // Scan order picks nearest-in-direction; last hit wins.
    for (int i = BW - 1; i >= 0; i--) begin
      if (i > cf && (lamp_in[i] | lamp_up[i])) begin
        up_near    = FB'(i);
        up_near_ok = 1'b1;
      end
      if (i < cf && lamp_up[i])
        dn_far = FB'(i);
    end
    for (int i = 0; i < BW; i++) begin
      if (i < cf && (lamp_in[i] | lamp_down[i])) begin
        dn_near    = FB'(i);
        dn_near_ok = 1'b1;
      end
      if (i > cf && lamp_down[i])
        up_far = FB'(i);
    end
    any_at = at_in | at_up | at_dn;
    up_tgt = up_near_ok ? up_near : up_far;
    dn_tgt = dn_near_ok ? dn_near : dn_far;
  end

  always_comb begin
    state_n = state;
    svc_n   = svc;
    turn_n  = turn;
    clr_in  = '0;
    clr_up  = '0;
    clr_dn  = '0;
    unique case (state)
      S_IDLE: begin
        if (any_at) begin
          state_n = S_STOP;
          svc_n   = D_IDLE;
          turn_n  = 1'b0;
        end else if (above) begin
          state_n = S_UP;
        end else if (below) begin
          state_n = S_DOWN;
        end
      end
      S_UP: begin
        if (at_floor) begin
          if (at_in || at_up || (at_dn && !above)) begin
            state_n = S_STOP;
            svc_n   = D_UP;
            turn_n  = !(at_in || at_up);
          end else if (!above) begin
            state_n = below ? S_DOWN : S_IDLE;
          end
        end
      end
      S_DOWN: begin
        if (at_floor) begin
          if (at_in || at_dn || (at_up && !below)) begin
            state_n = S_STOP;
            svc_n   = D_DOWN;
            turn_n  = !(at_in || at_dn);
          end else if (!below) begin
            state_n = above ? S_UP : S_IDLE;
          end
        end
      end
      S_STOP: begin
        if (door_done) begin
          clr_in = cur_oh;
          if (svc != D_DOWN || turn)
            clr_up = cur_oh;
          if (svc != D_UP || turn)
            clr_dn = cur_oh;
          if (svc == D_DOWN)
            state_n = below ? S_DOWN : (above ? S_UP : S_IDLE);
          else
            state_n = above ? S_UP : (below ? S_DOWN : S_IDLE);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    dir_n = 2'b00;
    tgt_n = cur_floor;
    unique case (state_n)
      S_UP: begin
        dir_n = 2'b01;
        tgt_n = up_tgt;
      end
      S_DOWN: begin
        dir_n = 2'b10;
        tgt_n = dn_tgt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      svc          <= D_IDLE;
      turn         <= 1'b0;
      dir          <= 2'b00;
      target       <= '0;
      target_valid <= 1'b0;
      open_req     <= 1'b0;
      lamp_in      <= '0;
      lamp_up      <= '0;
      lamp_down    <= '0;
    end else begin
      state        <= state_n;
      svc          <= svc_n;
      turn         <= turn_n;
      dir          <= dir_n;
      target       <= tgt_n;
      target_valid <= (state_n == S_UP) || (state_n == S_DOWN);
      open_req     <= (state_n == S_STOP) && (state != S_STOP);
      // A press on the same cycle as its clear keeps the lamp lit.
      lamp_in      <= (lamp_in & ~clr_in) | btn_in;
      lamp_up      <= (lamp_up & ~clr_up) | (btn_up_out & UP_MASK);
      lamp_down    <= (lamp_down & ~clr_dn) | (btn_down_out & DN_MASK);
    end
  end

endmodule

// File: tb/tb_floor_request_scheduler.sv
// Scoreboard bench for floor_request_scheduler with a cab/door plant
// and a floor-list reference model of the SCAN policy.
module tb_floor_request_scheduler;

  localparam int NF = 8;

  localparam int M_IDLE = 0;
  localparam int M_UP   = 1;
  localparam int M_DN   = 2;
  localparam int M_STP  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] btn_in = '0;
  logic [7:0] btn_up_out = '0;
  logic [7:0] btn_down_out = '0;
  logic [2:0] cur_floor = '0;
  logic       at_floor = 1'b1;
  logic       door_done = 1'b0;
  logic [1:0] dir;
  logic [2:0] target;
  logic       target_valid;
  logic       open_req;
  logic [7:0] lamp_in, lamp_up, lamp_down;

  floor_request_scheduler #(
    .BUTTONS_WIDTH(8),
    .FLOOR_BITS(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_in(btn_in),
    .btn_up_out(btn_up_out),
    .btn_down_out(btn_down_out),
    .cur_floor(cur_floor),
    .at_floor(at_floor),
    .door_done(door_done),
    .dir(dir),
    .target(target),
    .target_valid(target_valid),
    .open_req(open_req),
    .lamp_in(lamp_in),
    .lamp_up(lamp_up),
    .lamp_down(lamp_down)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] d;
    logic [2:0] t;
    logic       tv;
    logic       op;
    logic [7:0] li;
    logic [7:0] lu;
    logic [7:0] ld;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  int   m_st = M_IDLE;
  int   m_svc = M_IDLE;
  bit   m_trn = 0;
  bit   r_in[NF];
  bit   r_up[NF];
  bit   r_dn[NF];
  int   m_dir = 0;
  int   m_tgt = 0;
  bit   m_tv = 0;
  bit   m_op = 0;

  int   p_floor = 0;
  bit   p_at = 1;
  int   door_cnt = 0;
  bit   rand_mode = 0;
  bit   press_on_done = 0;
  int   open_count = 0;

  function automatic bit req(int i);
    return r_in[i] | r_up[i] | r_dn[i];
  endfunction

  function automatic bit any_above(int f);
    for (int i = f + 1; i < NF; i++)
      if (req(i)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit any_below(int f);
    for (int i = 0; i < f; i++)
      if (req(i)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit no_lamps();
    for (int i = 0; i < NF; i++)
      if (req(i)) return 1'b0;
    return 1'b1;
  endfunction

  // Nearest same-direction call first, else the farthest reverse call.
  function automatic int goal(int s, int f);
    if (s == M_UP) begin
      for (int i = f + 1; i < NF; i++)
        if (r_in[i] || r_up[i]) return i;
      for (int i = NF - 1; i > f; i--)
        if (r_dn[i]) return i;
    end else if (s == M_DN) begin
      for (int i = f - 1; i >= 0; i--)
        if (r_in[i] || r_dn[i]) return i;
      for (int i = 0; i < f; i++)
        if (r_up[i]) return i;
    end
    return f;
  endfunction

  task automatic model_step(bit rst, int f, bit at, bit dd,
                            bit [7:0] bi, bit [7:0] bu, bit [7:0] bd);
    bit ab, be;
    bit ci, cu, cd;
    int nst;
    if (rst) begin
      for (int i = 0; i < NF; i++) begin
        r_in[i] = 0;
        r_up[i] = 0;
        r_dn[i] = 0;
      end
      m_st  = M_IDLE;
      m_svc = M_IDLE;
      m_trn = 0;
      m_dir = 0;
      m_tgt = 0;
      m_tv  = 0;
      m_op  = 0;
      return;
    end
    ab  = any_above(f);
    be  = any_below(f);
    nst = m_st;
    ci  = 0;
    cu  = 0;
    cd  = 0;
    case (m_st)
      M_IDLE: begin
        if (req(f)) begin
          nst = M_STP; m_svc = M_IDLE; m_trn = 0;
        end else if (ab) nst = M_UP;
        else if (be) nst = M_DN;
      end
      M_UP: if (at) begin
        if (r_in[f] || r_up[f]) begin
          nst = M_STP; m_svc = M_UP; m_trn = 0;
        end else if (r_dn[f] && !ab) begin
          nst = M_STP; m_svc = M_UP; m_trn = 1;
        end else if (!ab) nst = be ? M_DN : M_IDLE;
      end
      M_DN: if (at) begin
        if (r_in[f] || r_dn[f]) begin
          nst = M_STP; m_svc = M_DN; m_trn = 0;
        end else if (r_up[f] && !be) begin
          nst = M_STP; m_svc = M_DN; m_trn = 1;
        end else if (!be) nst = ab ? M_UP : M_IDLE;
      end
      default: if (dd) begin
        ci = 1;
        cu = (m_svc == M_UP) || (m_svc == M_IDLE) || m_trn;
        cd = (m_svc == M_DN) || (m_svc == M_IDLE) || m_trn;
        if (m_svc == M_DN) nst = be ? M_DN : (ab ? M_UP : M_IDLE);
        else nst = ab ? M_UP : (be ? M_DN : M_IDLE);
      end
    endcase
    m_tgt = goal(nst, f);
    m_op  = (nst == M_STP) && (m_st != M_STP);
    m_tv  = (nst == M_UP) || (nst == M_DN);
    m_dir = (nst == M_UP) ? 1 : ((nst == M_DN) ? 2 : 0);
    if (ci) r_in[f] = 0;
    if (cu) r_up[f] = 0;
    if (cd) r_dn[f] = 0;
    for (int i = 0; i < NF; i++) begin
      if (bi[i]) r_in[i] = 1;
      if (bu[i] && i != NF - 1) r_up[i] = 1;
      if (bd[i] && i != 0) r_dn[i] = 1;
    end
    m_st = nst;
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.d  = 2'(m_dir);
    o.t  = 3'(m_tgt);
    o.tv = m_tv;
    o.op = m_op;
    for (int i = 0; i < NF; i++) begin
      o.li[i] = r_in[i];
      o.lu[i] = r_up[i];
      o.ld[i] = r_dn[i];
    end
    return o;
  endfunction

  task automatic cycle(bit rst, bit [7:0] bi, bit [7:0] bu, bit [7:0] bd);
    bit dd;
    @(negedge clk);
    if (m_dir == 1) begin
      if (p_at) p_at = 0;
      else begin
        if (p_floor < NF - 1) p_floor++;
        p_at = 1;
      end
    end else if (m_dir == 2) begin
      if (p_at) p_at = 0;
      else begin
        if (p_floor > 0) p_floor--;
        p_at = 1;
      end
    end else begin
      p_at = 1;
    end
    if (m_op) begin
      door_cnt = $urandom_range(1, 4);
      open_count++;
    end
    dd = 0;
    if (m_st == M_STP) begin
      if (door_cnt > 0) door_cnt--;
      dd = (door_cnt == 0);
    end
    if (rand_mode && m_st != M_STP && $urandom_range(0, 19) == 0)
      dd = 1;
    if (press_on_done && dd && m_st == M_STP) begin
      bi[p_floor]   = 1'b1;
      press_on_done = 0;
    end
    reset        = rst;
    btn_in       = bi;
    btn_up_out   = bu;
    btn_down_out = bd;
    cur_floor    = 3'(p_floor);
    at_floor     = p_at;
    door_done    = dd;
    model_step(rst, p_floor, p_at, dd, bi, bu, bd);
    exp_q.push_back(model_obs());
  endtask

  task automatic wait_idle(string tag, int limit);
    int n;
    n = 0;
    while (!(m_st == M_IDLE && no_lamps() && m_dir == 0) && n < limit) begin
      cycle(0, '0, '0, '0);
      n++;
    end
    checks++;
    if (n >= limit) begin
      errors++;
      $display("FAIL %s: still busy after %0d cycles, want idle", tag, n);
    end
  endtask

  always @(posedge clk) begin : monitor
    obs_t e, a;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {dir, target, target_valid, open_req, lamp_in, lamp_up, lamp_down};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs t=%0t: got dir=%b tgt=%0d tv=%b op=%b in=%b up=%b dn=%b, want dir=%b tgt=%0d tv=%b op=%b in=%b up=%b dn=%b",
                 $time, a.d, a.t, a.tv, a.op, a.li, a.lu, a.ld,
                 e.d, e.t, e.tv, e.op, e.li, e.lu, e.ld);
      end
    end
  end

  initial begin
    int n;
    int opens0;
    bit [7:0] bi, bu, bd;
    for (int i = 0; i < NF; i++) begin
      r_in[i] = 0;
      r_up[i] = 0;
      r_dn[i] = 0;
    end
    cycle(1, '0, '0, '0);
    cycle(1, '0, '0, '0);

    cycle(0, 8'h80, '0, '0);
    wait_idle("cabin_to_7", 200);

    cycle(0, '0, '0, 8'h80);
    wait_idle("hall_down_at_7", 200);
    cycle(0, '0, 8'h01, '0);
    wait_idle("turnaround_at_0", 200);

    cycle(0, 8'h20, 8'h04, 8'h08);
    wait_idle("collective_sweep", 300);

    cycle(0, '0, 8'h80, 8'h01);
    repeat (3) cycle(0, '0, '0, '0);

    cycle(0, 8'h80, 8'h20, 8'h40);
    n = 0;
    while (!(m_st == M_UP && p_floor == 4) && n < 100) begin
      cycle(0, '0, '0, '0);
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL reach_floor4: got floor %0d, want 4 while moving up", p_floor);
    end
    cycle(1, '0, '0, '0);
    cycle(0, '0, '0, '0);

    opens0 = open_count;
    press_on_done = 1;
    cycle(0, 8'h04, '0, '0);
    wait_idle("press_on_done", 300);
    checks++;
    if (open_count - opens0 != 2) begin
      errors++;
      $display("FAIL reopen: got %0d door opens, want 2", open_count - opens0);
    end

    rand_mode = 1;
    repeat (3000) begin
      bi = ($urandom_range(0, 11) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
      bu = ($urandom_range(0, 13) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
      bd = ($urandom_range(0, 13) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
      cycle($urandom_range(0, 599) == 0, bi, bu, bd);
    end
    rand_mode = 0;
    wait_idle("drain", 600);
    repeat (2) cycle(0, '0, '0, '0);
    @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
